// File: rtl/ysyx_22041207_mdu_pkg.sv
// rtl/ysyx_22041207_mdu_pkg.sv - shared encodings and helpers for the M-extension sequencing controller
//
// Contents:
//   MDU_XLEN, MDU_TIMEOUT_CYCLES  default datapath width and watchdog length
//   MDU_MUL..MDU_REMU             request op encodings (5-7 are reserved)
//   mdu_state_e                   controller state encoding
//   mdu_op_reserved()             true for encodings outside MUL..REMU
package ysyx_22041207_mdu_pkg;

    localparam int MDU_XLEN           = 64;
    localparam int MDU_TIMEOUT_CYCLES = 255;

    localparam logic [2:0] MDU_MUL  = 3'd0;
    localparam logic [2:0] MDU_DIV  = 3'd1;
    localparam logic [2:0] MDU_DIVU = 3'd2;
    localparam logic [2:0] MDU_REM  = 3'd3;
    localparam logic [2:0] MDU_REMU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mdu_state_e;

    function automatic logic mdu_op_reserved(input logic [2:0] op);
        return op > MDU_REMU;
    endfunction

endpackage

// File: rtl/ysyx_22041207_mdu_fixup.sv
// rtl/ysyx_22041207_mdu_fixup.sv - combinational operand extension, result select and divide fast path
//
// Optional feature macro: MDU_DIVZERO_FAST_EN (divide-by-zero / signed-overflow resolved here).
// Ports:
//   req_op, req_word, req_a, req_b   raw request fields (IDLE-side)
//   op_a, op_b                       operands after RV64 word-op extension
//   fast_hit, fast_data              division resolvable without the divider, and its result
//   cur_op, cur_word                 latched op of the operation in flight
//   mul_res, div_out, remain_out     unit results
//   result                           selected unit result, word-sign-extended when needed
module ysyx_22041207_mdu_fixup
    import ysyx_22041207_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic            fast_hit,
    output logic [XLEN-1:0] fast_data,
    input  logic [2:0]      cur_op,
    input  logic            cur_word,
    input  logic [XLEN-1:0] mul_res,
    input  logic [XLEN-1:0] div_out,
    input  logic [XLEN-1:0] remain_out,
    output logic [XLEN-1:0] result
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        return {{(XLEN-32){1'b0}}, x};
    endfunction

    // Signed word ops sign-extend; unsigned word ops and MULW zero-extend.
    always_comb begin
        op_a = req_a;
        op_b = req_b;
        if (req_word) begin
            if (req_op == MDU_DIV || req_op == MDU_REM) begin
                op_a = sext32(req_a[31:0]);
                op_b = sext32(req_b[31:0]);
            end else begin
                op_a = zext32(req_a[31:0]);
                op_b = zext32(req_b[31:0]);
            end
        end
    end

    logic [XLEN-1:0] raw_res;

    always_comb begin
        case (cur_op)
            MDU_DIV, MDU_DIVU: raw_res = div_out;
            MDU_REM, MDU_REMU: raw_res = remain_out;
            default:           raw_res = mul_res;
        endcase
        result = cur_word ? sext32(raw_res[31:0]) : raw_res;
    end

`ifdef MDU_DIVZERO_FAST_EN
    logic            div_op;
    logic            signed_op;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] most_neg;
    logic [XLEN-1:0] fast_raw;

    // Operands are already extended, so the word-op checks reduce to
    // 64-bit compares against the extended most-negative value and -1.
    always_comb begin
        div_op      = (req_op != MDU_MUL) && !mdu_op_reserved(req_op);
        signed_op   = (req_op == MDU_DIV) || (req_op == MDU_REM);
        div_by_zero = (op_b == '0);
        most_neg    = req_word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
        overflow    = signed_op && (op_a == most_neg) && (op_b == '1);
        fast_raw    = '0;
        if (div_by_zero) begin
            fast_raw = (req_op == MDU_DIV || req_op == MDU_DIVU) ? '1 : op_a;
        end else if (overflow) begin
            fast_raw = (req_op == MDU_DIV) ? op_a : '0;
        end
        fast_hit  = div_op && (div_by_zero || overflow);
        fast_data = req_word ? sext32(fast_raw[31:0]) : fast_raw;
    end
`else
    assign fast_hit  = 1'b0;
    assign fast_data = '0;
`endif

endmodule

// File: rtl/ysyx_22041207_mdu_ctrl.sv
// rtl/ysyx_22041207_mdu_ctrl.sv - sequencing controller for the EX-stage multiplier and divider
//
// Optional feature macro: MDU_DIVZERO_FAST_EN (see ysyx_22041207_mdu_fixup).
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   flush                            pipeline flush, aborts the operation
//   req_valid/req_ready, req_op, req_word, req_a, req_b     request port
//   resp_valid/resp_ready, resp_data, resp_err              response port
//   mul_valid/mul_ready, mul_out_valid, mul_res             multiplier port
//   div_valid/div_ready, div_sign, div_out_valid, div_out, remain_out   divider port
//   unit_a, unit_b                   extended operands shared by both units
//   unit_flush                       flush to both units (pipeline flush or watchdog)
//   busy                             an operation is in flight
module ysyx_22041207_mdu_ctrl
    import ysyx_22041207_mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MDU_TIMEOUT_CYCLES,
    parameter int XLEN           = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    output logic            mul_valid,
    input  logic            mul_ready,
    input  logic            mul_out_valid,
    input  logic [XLEN-1:0] mul_res,
    output logic            div_valid,
    output logic            div_sign,
    input  logic            div_ready,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_out,
    input  logic [XLEN-1:0] remain_out,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    output logic            unit_flush,
    output logic            busy
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mdu_state_e      state_q, state_d;
    logic [2:0]      op_q;
    logic            word_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [7:0]      count_q, count_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            load_req;
    logic            wd_fire;
    logic            unit_done;

    logic [XLEN-1:0] ext_a, ext_b, fast_data, result;
    logic            fast_hit;

    ysyx_22041207_mdu_fixup #(.XLEN(XLEN)) u_fixup (
        .req_op     (req_op),
        .req_word   (req_word),
        .req_a      (req_a),
        .req_b      (req_b),
        .op_a       (ext_a),
        .op_b       (ext_b),
        .fast_hit   (fast_hit),
        .fast_data  (fast_data),
        .cur_op     (op_q),
        .cur_word   (word_q),
        .mul_res    (mul_res),
        .div_out    (div_out),
        .remain_out (remain_out),
        .result     (result)
    );

    assign unit_done = (op_q == MDU_MUL) ? mul_out_valid : div_out_valid;

    always_comb begin
        state_d    = state_q;
        count_d    = '0;
        data_d     = data_q;
        err_d      = err_q;
        load_req   = 1'b0;
        wd_fire    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mul_valid  = 1'b0;
        div_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    load_req = 1'b1;
                    data_d   = '0;
                    err_d    = 1'b0;
                    if (mdu_op_reserved(req_op)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (fast_hit) begin
                        state_d = ST_DONE;
                        data_d  = fast_data;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Valid is masked during flush so the unit never sees a
                // handshake together with its own flush.
                if (op_q == MDU_MUL) begin
                    mul_valid = !flush;
                    if (mul_ready) state_d = ST_WAIT;
                end else begin
                    div_valid = !flush;
                    if (div_ready) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                count_d = count_q + 8'd1;
                // The watchdog wins over a result arriving on its final cycle.
                if (count_q == TIMEOUT_LAST) begin
                    wd_fire = 1'b1;
                    state_d = ST_DONE;
                    data_d  = '0;
                    err_d   = 1'b1;
                    count_d = '0;
                end else if (unit_done) begin
                    state_d = ST_DONE;
                    data_d  = result;
                    count_d = '0;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            data_d   = data_q;
            err_d    = err_q;
            load_req = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            count_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            err_q   <= err_d;
            if (load_req) begin
                op_q   <= req_op;
                word_q <= req_word;
                a_q    <= ext_a;
                b_q    <= ext_b;
            end
        end
    end

    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign div_sign   = (state_q == ST_ISSUE || state_q == ST_WAIT)
                        && (op_q == MDU_DIV || op_q == MDU_REM);
    assign unit_flush = flush | wd_fire;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22041207_mdu_ctrl.sv
// tb/tb_ysyx_22041207_mdu_ctrl.sv - directed self-checking bench for ysyx_22041207_mdu_ctrl
module tb_ysyx_22041207_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_word;
    logic [63:0] req_a, req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        mul_valid, mul_ready, mul_out_valid;
    logic [63:0] mul_res;
    logic        div_valid, div_sign, div_ready, div_out_valid;
    logic [63:0] div_out, remain_out;
    logic [63:0] unit_a, unit_b;
    logic        unit_flush;
    logic        busy;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ysyx_22041207_mdu_ctrl #(.TIMEOUT_CYCLES(16), .XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_out_valid(mul_out_valid), .mul_res(mul_res),
        .div_valid(div_valid), .div_sign(div_sign), .div_ready(div_ready),
        .div_out_valid(div_out_valid), .div_out(div_out), .remain_out(remain_out),
        .unit_a(unit_a), .unit_b(unit_b), .unit_flush(unit_flush), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_word = 1'b0;
        req_a = '0; req_b = '0; resp_ready = 1'b0;
        mul_ready = 1'b0; mul_out_valid = 1'b0; mul_res = '0;
        div_ready = 1'b0; div_out_valid = 1'b0; div_out = '0; remain_out = '0;
        tick(); tick();
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, mul_valid, div_valid, div_sign, busy, unit_flush} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {resp_valid, resp_err, mul_valid, div_valid, div_sign, busy, unit_flush});
        end
        vec++;
        if (resp_data !== 64'd0) begin errs++; $display("FAIL reset_data got %h exp 0", resp_data); end
        vec++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        tick();
        rst = 1'b1;
    endtask

    // MUL 3 * -2, unit latency 4 -> response at accept+6
    task automatic test_mul();
        tick();
        req_valid = 1'b1; req_op = 3'd0; req_word = 1'b0;
        req_a = 64'd3; req_b = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        vec++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL mul_accept got %b exp 1", req_ready); end
        tick(); // N+1
        req_valid = 1'b0; mul_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({mul_valid, div_valid, busy, unit_a, unit_b} !== {3'b101, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE}) begin
            errs++;
            $display("FAIL mul_issue got %b %h %h exp 101 3 fffffffffffffffe",
                     {mul_valid, div_valid, busy}, unit_a, unit_b);
        end
        tick(); // N+2
        mul_ready = 1'b0;
        @(negedge clk);
        vec++;
        if ({mul_valid, busy, resp_valid} !== 3'b010) begin
            errs++; $display("FAIL mul_wait got %b exp 010", {mul_valid, busy, resp_valid});
        end
        tick(); tick(); tick(); // N+5
        mul_out_valid = 1'b1; mul_res = 64'hFFFF_FFFF_FFFF_FFFA;
        @(negedge clk);
        vec++;
        if (resp_valid !== 1'b0) begin errs++; $display("FAIL mul_early_resp got %b exp 0", resp_valid); end
        tick(); // N+6
        mul_out_valid = 1'b0; mul_res = '0;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, req_ready, resp_data} !== {3'b100, 64'hFFFF_FFFF_FFFF_FFFA}) begin
            errs++;
            $display("FAIL mul_resp got %b %h exp 100 fffffffffffffffa",
                     {resp_valid, resp_err, req_ready}, resp_data);
        end
        tick(); // N+7: held, then consumed
        resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_data} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFA}) begin
            errs++; $display("FAIL mul_hold got %b %h exp 1 fffffffffffffffa", resp_valid, resp_data);
        end
        tick(); // N+8
        resp_ready = 1'b0;
        @(negedge clk);
        vec++;
        if ({resp_valid, req_ready, busy} !== 3'b010) begin
            errs++; $display("FAIL mul_release got %b exp 010", {resp_valid, req_ready, busy});
        end
    endtask

    // DIVW 0x80000000 / -1
    task automatic test_divw();
        tick();
        req_valid = 1'b1; req_op = 3'd1; req_word = 1'b1;
        req_a = 64'h0000_0000_8000_0000; req_b = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); // N+1
        req_valid = 1'b0;
`ifdef MDU_DIVZERO_FAST_EN
        resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, div_valid, resp_data} !== {3'b100, 64'hFFFF_FFFF_8000_0000}) begin
            errs++;
            $display("FAIL divw_fast got %b %h exp 100 ffffffff80000000",
                     {resp_valid, resp_err, div_valid}, resp_data);
        end
        tick();
        resp_ready = 1'b0;
`else
        @(negedge clk);
        vec++;
        if ({div_valid, div_sign, mul_valid, unit_a, unit_b} !==
            {3'b110, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            errs++;
            $display("FAIL divw_issue got %b %h %h exp 110 ffffffff80000000 ffffffffffffffff",
                     {div_valid, div_sign, mul_valid}, unit_a, unit_b);
        end
        tick(); // N+2: divider not ready yet
        div_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (div_valid !== 1'b1) begin errs++; $display("FAIL divw_hold_valid got %b exp 1", div_valid); end
        tick(); // N+3: WAIT
        div_ready = 1'b0;
        @(negedge clk);
        vec++;
        if ({div_valid, div_sign} !== 2'b01) begin
            errs++; $display("FAIL divw_wait got %b exp 01", {div_valid, div_sign});
        end
        tick(); // N+4
        div_out_valid = 1'b1; div_out = 64'h0000_0000_8000_0000; remain_out = 64'h1234;
        tick(); // N+5
        div_out_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, resp_data} !== {2'b10, 64'hFFFF_FFFF_8000_0000}) begin
            errs++;
            $display("FAIL divw_resp got %b %h exp 10 ffffffff80000000", {resp_valid, resp_err}, resp_data);
        end
        tick();
        resp_ready = 1'b0;
`endif
    endtask

    // MULW zero-extends operands, sign-extends result; DIVU 64-bit passes result untouched
    task automatic test_word_select();
        tick();
        req_valid = 1'b1; req_op = 3'd0; req_word = 1'b1;
        req_a = 64'hFFFF_FFFF_0000_0003; req_b = 64'h1234_5678_8000_0001;
        tick();
        req_valid = 1'b0; mul_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({unit_a, unit_b} !== {64'h0000_0000_0000_0003, 64'h0000_0000_8000_0001}) begin
            errs++; $display("FAIL mulw_operands got %h %h exp 3 80000001", unit_a, unit_b);
        end
        tick();
        mul_ready = 1'b0; mul_out_valid = 1'b1; mul_res = 64'h0000_0001_8000_0003;
        tick();
        mul_out_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_data} !== {1'b1, 64'hFFFF_FFFF_8000_0003}) begin
            errs++; $display("FAIL mulw_resp got %b %h exp 1 ffffffff80000003", resp_valid, resp_data);
        end
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 3'd2; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7;
        tick();
        req_valid = 1'b0; div_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({div_valid, div_sign} !== 2'b10) begin
            errs++; $display("FAIL divu_issue got %b exp 10", {div_valid, div_sign});
        end
        tick();
        div_ready = 1'b0; div_out_valid = 1'b1; div_out = 64'h0000_0000_8000_0000; remain_out = 64'd2;
        tick();
        div_out_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_data} !== {1'b1, 64'h0000_0000_8000_0000}) begin
            errs++; $display("FAIL divu_resp got %b %h exp 1 0000000080000000", resp_valid, resp_data);
        end
        tick();
        resp_ready = 1'b0;
    endtask

    // REMU 7 % 0
    task automatic test_remu_zero();
        tick();
        req_valid = 1'b1; req_op = 3'd4; req_word = 1'b0; req_a = 64'd7; req_b = 64'd0;
        tick(); // N+1
        req_valid = 1'b0;
`ifdef MDU_DIVZERO_FAST_EN
        resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, div_valid, resp_data} !== {2'b10, 64'd7}) begin
            errs++; $display("FAIL remu_fast got %b %h exp 10 7", {resp_valid, div_valid}, resp_data);
        end
`else
        div_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({div_valid, div_sign} !== 2'b10) begin
            errs++; $display("FAIL remu_issue got %b exp 10", {div_valid, div_sign});
        end
        tick(); // N+2
        div_ready = 1'b0; div_out_valid = 1'b1; div_out = 64'hFFFF_FFFF_FFFF_FFFF; remain_out = 64'd7;
        tick(); // N+3
        div_out_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, resp_data} !== {2'b10, 64'd7}) begin
            errs++; $display("FAIL remu_resp got %b %h exp 10 7", {resp_valid, resp_err}, resp_data);
        end
`endif
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reserved_op();
        tick();
        req_valid = 1'b1; req_op = 3'd6; req_word = 1'b0; req_a = 64'd9; req_b = 64'd9;
        tick();
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, mul_valid, div_valid, resp_data} !== {4'b1100, 64'd0}) begin
            errs++;
            $display("FAIL reserved_resp got %b %h exp 1100 0", {resp_valid, resp_err, mul_valid, div_valid}, resp_data);
        end
        tick();
        resp_ready = 1'b0;
        @(negedge clk);
        vec++;
        if ({busy, req_ready} !== 2'b01) begin errs++; $display("FAIL reserved_idle got %b exp 01", {busy, req_ready}); end
    endtask

    task automatic test_flush_wait();
        logic seen;
        tick();
        req_valid = 1'b1; req_op = 3'd2; req_word = 1'b0; req_a = 64'd10; req_b = 64'd3;
        tick(); // N+1
        req_valid = 1'b0; div_ready = 1'b1;
        tick(); // N+2 WAIT
        div_ready = 1'b0;
        tick(); // N+3: flush with a colliding result
        flush = 1'b1; div_out_valid = 1'b1; div_out = 64'd3;
        @(negedge clk);
        vec++;
        if (unit_flush !== 1'b1) begin errs++; $display("FAIL flush_unit_flush got %b exp 1", unit_flush); end
        tick(); // N+4
        flush = 1'b0; div_out_valid = 1'b0;
        @(negedge clk);
        vec++;
        if ({resp_valid, req_ready, busy, unit_flush, div_valid} !== 5'b01000) begin
            errs++;
            $display("FAIL flush_after got %b exp 01000", {resp_valid, req_ready, busy, unit_flush, div_valid});
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        vec++;
        if (seen !== 1'b0) begin errs++; $display("FAIL flush_no_resp got %b exp 0", seen); end
        tick(); // flush in IDLE blocks accept
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0;
        @(negedge clk);
        vec++;
        if (req_ready !== 1'b0) begin errs++; $display("FAIL flush_idle_ready got %b exp 0", req_ready); end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        vec++;
        if (busy !== 1'b0) begin errs++; $display("FAIL flush_idle_busy got %b exp 0", busy); end
    endtask

    // TIMEOUT_CYCLES = 16: WAIT from N+2, watchdog fires in N+17
    task automatic test_watchdog();
        logic early;
        logic unstable;
        tick();
        req_valid = 1'b1; req_op = 3'd1; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7;
        tick(); // N+1
        req_valid = 1'b0; div_ready = 1'b1;
        tick(); // N+2
        div_ready = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if ({unit_flush, resp_valid} !== 2'b00) early = 1'b1;
            tick();
        end
        vec++;
        if (early !== 1'b0) begin errs++; $display("FAIL wd_early got %b exp 0", early); end
        @(negedge clk); // N+17
        vec++;
        if (unit_flush !== 1'b1) begin errs++; $display("FAIL wd_pulse got %b exp 1", unit_flush); end
        tick(); // N+18
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, unit_flush, resp_data} !== {3'b110, 64'd0}) begin
            errs++;
            $display("FAIL wd_resp got %b %h exp 110 0", {resp_valid, resp_err, unit_flush}, resp_data);
        end
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            if ({resp_valid, resp_err, resp_data} !== {2'b11, 64'd0}) unstable = 1'b1;
        end
        vec++;
        if (unstable !== 1'b0) begin errs++; $display("FAIL wd_stable got %b exp 0", unstable); end
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        @(negedge clk);
        vec++;
        if ({resp_valid, busy} !== 2'b00) begin errs++; $display("FAIL wd_release got %b exp 00", {resp_valid, busy}); end
    endtask

    task automatic test_reset_mid_issue();
        tick();
        req_valid = 1'b1; req_op = 3'd0; req_word = 1'b0; req_a = 64'd5; req_b = 64'd5;
        tick(); // ISSUE, unit not ready
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        vec++;
        if ({mul_valid, div_valid, busy, unit_flush} !== 4'b0000) begin
            errs++; $display("FAIL rst_async got %b exp 0000", {mul_valid, div_valid, busy, unit_flush});
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        req_valid = 1'b1; req_op = 3'd0; req_a = 64'd5; req_b = 64'd5;
        tick();
        req_valid = 1'b0; mul_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({mul_valid, unit_a, unit_b} !== {1'b1, 64'd5, 64'd5}) begin
            errs++; $display("FAIL rst_mul_issue got %b %h %h exp 1 5 5", mul_valid, unit_a, unit_b);
        end
        tick();
        mul_ready = 1'b0; mul_out_valid = 1'b1; mul_res = 64'd25;
        tick();
        mul_out_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if ({resp_valid, resp_err, resp_data} !== {2'b10, 64'd25}) begin
            errs++; $display("FAIL rst_mul_resp got %b %h exp 10 25", {resp_valid, resp_err}, resp_data);
        end
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_divw();
        test_word_select();
        test_remu_zero();
        test_reserved_op();
        test_flush_wait();
        test_watchdog();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
